cgra_config_streamer: RTL and testbench
=======================================

Name: cgra_config_streamer

Overview:
- Parametrised successor to the fixed-image serial CGRA configurator.
- Fetches the configuration image word by word from an external memory read port instead of embedding it, serialises it onto NUM_CHAINS parallel scan chains, and signals completion.
- Sits between the config memory/host loader and the CGRA fabric's config scan chains.
- Adds over the previous generation: multi-chain output, restartable loads from any base address, stall support, and prefetch so that streaming has no gaps.

Parameters:
- NUM_CHAINS, 1, number of parallel scan chains (bits emitted per shift cycle); must divide WORD_W.
- BITS_PER_CHAIN, 1097, config bits per chain; number of shift cycles per load.
- WORD_W, 32, memory data width.
- ADDR_W, 16, memory word address width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load from base_addr
- base_addr  in  ADDR_W  word address of image; sampled on accepted start
- enable  in  1  0 = freeze shifting (fabric not ready)
- rd_req  out  1  one-cycle read request pulse
- rd_addr  out  ADDR_W  address qualified by rd_req
- rd_valid  in  1  read data valid; latency ≥1 cycle, unbounded
- rd_data  in  WORD_W  read data
- bitstream  out  NUM_CHAINS  bit c drives chain c
- shift_en  out  1  bitstream valid this cycle; chains shift when high
- busy  out  1  load in progress
- done  out  1  sticky; load complete

Behaviour:
- Reset values: rd_req=0, rd_addr=0, bitstream=0, shift_en=0, busy=0, done=0. State = IDLE.
- Reset asserted mid-load aborts immediately. There is no resume.
- Image layout:
  - One "slice" is NUM_CHAINS bits.
  - Slice k, chain c takes image bit k*NUM_CHAINS+c, read LSB-first from consecutive words.
  - Words fetched per load: NWORDS = ceil(BITS_PER_CHAIN*NUM_CHAINS/WORD_W).
  - Unused high bits of the last word are discarded.
- States:
  - IDLE: start → FETCH; latch base_addr; busy=1; done=0.
  - FETCH: issue the first read; wait rd_valid; load the word into the shift register → SHIFT.
  - SHIFT: each cycle where enable=1 and a slice is available:
    - register the slice onto bitstream with shift_en=1;
    - shift the register right by NUM_CHAINS;
    - increment the slice counter.
  - SHIFT → DONE when the slice counter reaches BITS_PER_CHAIN.
  - DONE: busy=0, done=1 (sticky), shift_en=0, bitstream=0. start → FETCH (restart).
- bitstream and shift_en are registered: one cycle after the slice decision.
- Prefetch:
  - One-entry word buffer.
  - When the buffer is empty, no request is outstanding, and words remain, pulse rd_req with the next address.
  - At most one request is outstanding.
- Gapless reload: when the current word's last slice shifts and the buffer is full, the buffer moves into the shift register in the same cycle, so shift_en has no bubble.
- Buffer empty at a word boundary: shift_en=0 until rd_valid. The data may be shifted out the cycle after rd_valid.
- enable=0: shift_en=0 and the slice counter holds. Prefetch still proceeds.
- Ignored events:
  - start while busy.
  - rd_valid with no outstanding request.
  - Fetches beyond NWORDS are never issued.
- rd_addr wraps modulo 2^ADDR_W.
- Counters: slice counter $clog2(BITS_PER_CHAIN+1) bits; word counter $clog2(NWORDS+1) bits.

Optional Feature:
- Macro: CONFIG_CRC_EN.
- When defined:
  - Adds input expected_crc[15:0] and outputs crc[15:0], crc_ok.
  - CRC-16-CCITT: poly 0x1021, init 0xFFFF, MSB-first shift. Fed with every emitted bit, chain 0 first within each slice (NUM_CHAINS bits per cycle, unrolled).
  - crc is reset to 0xFFFF on accepted start.
  - crc_ok is registered together with the DONE entry: 1 iff crc==expected_crc. Cleared on start and reset.
- When not defined: these ports are absent and there is no CRC logic.

Decomposition:
- Package cgra_config_pkg:
  - state enum {IDLE, FETCH, SHIFT, DONE};
  - CRC_POLY=16'h1021, CRC_INIT=16'hFFFF;
  - function nwords(bits, chains, w).
- Sub-module cgra_config_word_buf: one-entry word buffer with full flag, load on rd_valid, pop on reload.
- The CRC update is a package function, not a separate module.

Test Plan:
- NUM_CHAINS=1, BITS_PER_CHAIN=40, WORD_W=32, memory at base 0x10 = {0x0000_00A5, 0x0000_003C}, 1-cycle latency, enable=1:
  - exactly 40 shift_en cycles with no gaps;
  - the first 8 bits are 1,0,1,0,0,1,0,1;
  - bits 32..39 are 0,0,1,1,1,1,0,0;
  - done=1 afterwards;
  - exactly 2 rd_req pulses, at addresses 0x10 and 0x11.
- NUM_CHAINS=4, BITS_PER_CHAIN=16, word 0x7654_3210 then 0xFEDC_BA98:
  - slices are 0x0,0x1,…,0xF on bitstream[3:0];
  - 16 shift cycles.
- Memory latency 10 cycles:
  - shift_en drops at each word boundary until rd_valid;
  - no bits are duplicated or lost;
  - the total shift_en count equals BITS_PER_CHAIN.
- enable toggling 1/0 each cycle, plus start pulsed mid-load:
  - the mid-load start is ignored;
  - shift_en is never high while enable=0;
  - the output sequence is identical to the enable=1 run.
- reset_n low mid-SHIFT:
  - all outputs are 0 asynchronously.
  - After release, start from DONE and a restart at a new base_addr both produce a complete correct stream.
  - A spurious rd_valid while IDLE has no effect.
- With CONFIG_CRC_EN, 40-bit image above:
  - matching expected_crc → crc_ok=1;
  - expected_crc XOR 1 → crc_ok=0;
  - crc_ok clears on the next start.

Source files
------------

// File: rtl/cgra_config_pkg.sv
// Shared state encoding, CRC constants and sizing helpers for the CGRA config streamer.
package cgra_config_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic int nwords(input int bits, input int chains, input int w);
        return (bits * chains + w - 1) / w;
    endfunction

    // One MSB-first CRC-16-CCITT step for a single serial bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic [15:0] nxt;
        nxt = {crc[14:0], 1'b0};
        if (crc[15] ^ din) nxt = nxt ^ CRC_POLY;
        return nxt;
    endfunction

endpackage

// File: rtl/cgra_config_word_buf.sv
// One-entry prefetch buffer between the config memory read port and the shift register.
module cgra_config_word_buf #(
    parameter int WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              pop,
    output logic              full,
    output logic [WORD_W-1:0] data
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cgra_config_streamer.sv
// Streams a memory-resident configuration image onto NUM_CHAINS scan chains with prefetch.
// Optional CRC-16-CCITT check of the emitted stream when CONFIG_CRC_EN is defined.
module cgra_config_streamer
    import cgra_config_pkg::*;
#(
    parameter int NUM_CHAINS     = 1,
    parameter int BITS_PER_CHAIN = 1097,
    parameter int WORD_W         = 32,
    parameter int ADDR_W         = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  enable,
    output logic                  rd_req,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic                  rd_valid,
    input  logic [WORD_W-1:0]     rd_data,
    output logic [NUM_CHAINS-1:0] bitstream,
    output logic                  shift_en,
    output logic                  busy,
    output logic                  done
`ifdef CONFIG_CRC_EN
    ,
    input  logic [15:0]           expected_crc,
    output logic [15:0]           crc,
    output logic                  crc_ok
`endif
);

    localparam int NWORDS  = nwords(BITS_PER_CHAIN, NUM_CHAINS, WORD_W);
    localparam int SPW     = WORD_W / NUM_CHAINS;
    localparam int SLICE_W = $clog2(BITS_PER_CHAIN + 1);
    localparam int WCNT_W  = $clog2(NWORDS + 1);
    localparam int LEFT_W  = $clog2(SPW + 1);

    localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(BITS_PER_CHAIN - 1);
    localparam logic [WCNT_W-1:0]  NWORDS_C   = WCNT_W'(NWORDS);
    localparam logic [LEFT_W-1:0]  SPW_C      = LEFT_W'(SPW);

    state_t              state;
    logic [ADDR_W-1:0]   next_addr;
    logic [WCNT_W-1:0]   req_cnt;
    logic                outstanding;
    logic [WORD_W-1:0]   sreg;
    logic [LEFT_W-1:0]   sreg_left;
    logic [SLICE_W-1:0]  slice_cnt;

    logic                buf_full;
    logic [WORD_W-1:0]   buf_data;
    logic                buf_clear;
    logic                pop;
    logic                accept;
    logic                issue;
    logic                use_buf;
    logic                do_shift;
    logic [WORD_W-1:0]   cur_word;
    logic [LEFT_W-1:0]   cur_left;

    // An exhausted shift register reads straight from the buffer, which makes word
    // reloads gapless and lets data shift out the cycle after it lands in the buffer.
    always_comb begin
        use_buf   = (sreg_left == '0) && buf_full;
        cur_word  = use_buf ? buf_data : sreg;
        cur_left  = use_buf ? SPW_C : sreg_left;
        do_shift  = (state == SHIFT) && enable && (cur_left != '0);
        pop       = (state == SHIFT) && use_buf;
        accept    = rd_valid && outstanding;
        buf_clear = ((state == IDLE) || (state == DONE)) && start;
        issue     = ((state == FETCH) || (state == SHIFT)) && !buf_full &&
                    !outstanding && (req_cnt != NWORDS_C);
    end

    cgra_config_word_buf #(
        .WORD_W (WORD_W)
    ) u_word_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (buf_clear),
        .load      (accept),
        .load_data (rd_data),
        .pop       (pop),
        .full      (buf_full),
        .data      (buf_data)
    );

`ifdef CONFIG_CRC_EN
    logic [15:0]           crc_next;
    logic [NUM_CHAINS-1:0] crc_bits;

    always_comb begin
        crc_next = crc;
        crc_bits = cur_word[NUM_CHAINS-1:0];
        for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
            crc_next = crc16_step(crc_next, crc_bits[0]);
            crc_bits = crc_bits >> 1;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            next_addr   <= '0;
            req_cnt     <= '0;
            outstanding <= 1'b0;
            sreg        <= '0;
            sreg_left   <= '0;
            slice_cnt   <= '0;
            bitstream   <= '0;
            shift_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef CONFIG_CRC_EN
            crc         <= CRC_INIT;
            crc_ok      <= 1'b0;
`endif
        end else begin
            rd_req    <= 1'b0;
            shift_en  <= 1'b0;
            bitstream <= '0;

            if (issue) begin
                rd_req      <= 1'b1;
                rd_addr     <= next_addr;
                next_addr   <= next_addr + 1'b1;
                req_cnt     <= req_cnt + 1'b1;
                outstanding <= 1'b1;
            end else if (accept) begin
                outstanding <= 1'b0;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= FETCH;
                        next_addr   <= base_addr;
                        req_cnt     <= '0;
                        outstanding <= 1'b0;
                        sreg_left   <= '0;
                        slice_cnt   <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
`ifdef CONFIG_CRC_EN
                        crc         <= CRC_INIT;
                        crc_ok      <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    if (accept) state <= SHIFT;
                end
                SHIFT: begin
                    if (do_shift) begin
                        bitstream <= cur_word[NUM_CHAINS-1:0];
                        shift_en  <= 1'b1;
                        sreg      <= cur_word >> NUM_CHAINS;
                        sreg_left <= cur_left - 1'b1;
                        slice_cnt <= slice_cnt + 1'b1;
`ifdef CONFIG_CRC_EN
                        crc       <= crc_next;
`endif
                        if (slice_cnt == LAST_SLICE) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`ifdef CONFIG_CRC_EN
                            crc_ok <= (crc_next == expected_crc);
`endif
                        end
                    end else if (use_buf) begin
                        sreg      <= buf_data;
                        sreg_left <= SPW_C;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_config_streamer.sv
// Directed self-checking bench: a 1-chain/40-bit instance and a 4-chain/16-bit instance.
module tb_cgra_config_streamer;

    localparam int AW = 16;
    localparam int WW = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset_n;

    logic          start1 = 1'b0, enable1 = 1'b1, rd_valid1 = 1'b0;
    logic          rd_req1, shift_en1, busy1, done1;
    logic [AW-1:0] base1 = '0, rd_addr1;
    logic [WW-1:0] rd_data1 = '0;
    logic [0:0]    bs1;

    logic          start4 = 1'b0, enable4 = 1'b1, rd_valid4 = 1'b0;
    logic          rd_req4, shift_en4, busy4, done4;
    logic [AW-1:0] base4 = '0, rd_addr4;
    logic [WW-1:0] rd_data4 = '0;
    logic [3:0]    bs4;
`ifdef CONFIG_CRC_EN
    logic [15:0]   exp_crc1 = '0, exp_crc4 = '0, crc1, crc4;
    logic          crc_ok1, crc_ok4;
`endif

    cgra_config_streamer #(.NUM_CHAINS(1), .BITS_PER_CHAIN(40), .WORD_W(WW), .ADDR_W(AW)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .start(start1), .base_addr(base1), .enable(enable1),
        .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_valid(rd_valid1), .rd_data(rd_data1),
        .bitstream(bs1), .shift_en(shift_en1), .busy(busy1), .done(done1)
`ifdef CONFIG_CRC_EN
        , .expected_crc(exp_crc1), .crc(crc1), .crc_ok(crc_ok1)
`endif
    );

    cgra_config_streamer #(.NUM_CHAINS(4), .BITS_PER_CHAIN(16), .WORD_W(WW), .ADDR_W(AW)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .start(start4), .base_addr(base4), .enable(enable4),
        .rd_req(rd_req4), .rd_addr(rd_addr4), .rd_valid(rd_valid4), .rd_data(rd_data4),
        .bitstream(bs4), .shift_en(shift_en4), .busy(busy4), .done(done4)
`ifdef CONFIG_CRC_EN
        , .expected_crc(exp_crc4), .crc(crc4), .crc_ok(crc_ok4)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Memory model: fixed latency in cycles, one request at a time per port.
    logic [WW-1:0] mem [256];
    int            latency = 1;
    int            pend1 = 0, pend4 = 0;
    logic [AW-1:0] maddr1 = '0, maddr4 = '0;
    logic          inject1 = 1'b0;

    always @(negedge clock) begin
        rd_valid1 = 1'b0;
        rd_valid4 = 1'b0;
        if (!reset_n) begin
            pend1 = 0;
            pend4 = 0;
        end else begin
            if (pend1 > 0) begin
                pend1--;
                if (pend1 == 0) begin rd_valid1 = 1'b1; rd_data1 = mem[maddr1[7:0]]; end
            end
            if (pend4 > 0) begin
                pend4--;
                if (pend4 == 0) begin rd_valid4 = 1'b1; rd_data4 = mem[maddr4[7:0]]; end
            end
        end
        if (rd_req1) begin pend1 = latency; maddr1 = rd_addr1; end
        if (rd_req4) begin pend4 = latency; maddr4 = rd_addr4; end
        if (inject1) begin rd_valid1 = 1'b1; rd_data1 = 32'hDEAD_BEEF; inject1 = 1'b0; end
    end

    // Output logger
    int            cyc = 0;
    logic          bits1 [$];
    logic [3:0]    sl4 [$];
    logic [AW-1:0] addrs1 [$], addrs4 [$];
    int            first1 = -1, last1 = -1, first4 = -1, last4 = -1, viol1 = 0;
    logic          en_edge1 = 1'b1, toggle1 = 1'b0;

    always @(posedge clock) en_edge1 = enable1;

    always @(negedge clock) begin
        cyc++;
        if (shift_en1) begin
            bits1.push_back(bs1[0]);
            if (first1 < 0) first1 = cyc;
            last1 = cyc;
            if (!en_edge1) viol1++;
        end
        if (shift_en4) begin
            sl4.push_back(bs4);
            if (first4 < 0) first4 = cyc;
            last4 = cyc;
        end
        if (rd_req1) addrs1.push_back(rd_addr1);
        if (rd_req4) addrs4.push_back(rd_addr4);
        if (toggle1) enable1 = ~enable1;
    end

    task automatic clear_log();
        bits1.delete(); sl4.delete(); addrs1.delete(); addrs4.delete();
        first1 = -1; last1 = -1; first4 = -1; last4 = -1; viol1 = 0;
    endtask

    task automatic pulse_start1(input logic [AW-1:0] b);
        @(negedge clock); base1 = b; start1 = 1'b1;
        @(negedge clock); start1 = 1'b0;
    endtask

    task automatic pulse_start4(input logic [AW-1:0] b);
        @(negedge clock); base4 = b; start4 = 1'b1;
        @(negedge clock); start4 = 1'b0;
    endtask

    task automatic wait_done1(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done1) begin ok = 1'b1; break; end
        end
        @(negedge clock);
    endtask

    task automatic wait_done4(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done4) begin ok = 1'b1; break; end
        end
        @(negedge clock);
    endtask

    function automatic logic [39:0] stream1();
        logic [39:0] v = '0;
        for (int i = 0; i < 40; i++) v = {((i < bits1.size()) ? bits1[i] : 1'bx), v[39:1]};
        return v;
    endfunction

    function automatic logic [63:0] stream4();
        logic [63:0] v = '0;
        for (int i = 0; i < 16; i++) v = {((i < sl4.size()) ? sl4[i] : 4'bx), v[63:4]};
        return v;
    endfunction

    function automatic logic [31:0] addr_pair1();
        return (addrs1.size() == 2) ? {addrs1[0], addrs1[1]} : 32'bx;
    endfunction

    function automatic logic [31:0] addr_pair4();
        return (addrs4.size() == 2) ? {addrs4[0], addrs4[1]} : 32'bx;
    endfunction

    task automatic run1(input logic [AW-1:0] b, output bit ok);
        clear_log();
        pulse_start1(b);
        wait_done1(400, ok);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({rd_req1, rd_addr1, bs1, shift_en1, busy1, done1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: got %h expected 0", {rd_req1, rd_addr1, bs1, shift_en1, busy1, done1});
        end
        checks++;
        if ({rd_req4, rd_addr4, bs4, shift_en4, busy4, done4} !== '0) begin
            errors++;
            $display("FAIL reset_dut4: got %h expected 0", {rd_req4, rd_addr4, bs4, shift_en4, busy4, done4});
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        clear_log();
        repeat (4) @(negedge clock);
        checks++;
        if ({busy1, done1, busy4, done4} !== 4'b0 || addrs1.size() != 0 || addrs4.size() != 0) begin
            errors++;
            $display("FAIL idle_quiet: busy/done %b reqs %0d/%0d expected 0000 0/0",
                     {busy1, done1, busy4, done4}, addrs1.size(), addrs4.size());
        end
    endtask

    task automatic test_basic_stream();
        bit ok;
        latency = 1;
        enable1 = 1'b1;
        run1(16'h0010, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: done never rose"); end
        checks++;
        if (bits1.size() != 40) begin errors++; $display("FAIL basic_count: got %0d expected 40", bits1.size()); end
        checks++;
        if (last1 - first1 + 1 != 40) begin errors++; $display("FAIL basic_gapless: span %0d expected 40", last1 - first1 + 1); end
        checks++;
        if (stream1() !== 40'h3C_0000_00A5) begin errors++; $display("FAIL basic_stream: got %h expected 3c000000a5", stream1()); end
        checks++;
        if ({busy1, done1} !== 2'b01) begin errors++; $display("FAIL basic_done: busy,done %b expected 01", {busy1, done1}); end
        checks++;
        if (addr_pair1() !== 32'h0010_0011) begin errors++; $display("FAIL basic_addrs: got %h (n=%0d) expected 00100011", addr_pair1(), addrs1.size()); end
        repeat (3) @(negedge clock);
        checks++;
        if ({shift_en1, bs1, done1} !== 3'b001) begin errors++; $display("FAIL basic_quiet_after: shift_en,bs,done %b expected 001", {shift_en1, bs1, done1}); end
    endtask

    task automatic test_multichain();
        bit ok;
        latency = 1;
        clear_log();
        pulse_start4(16'h0040);
        wait_done4(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL multi_timeout: done never rose"); end
        checks++;
        if (sl4.size() != 16) begin errors++; $display("FAIL multi_count: got %0d expected 16", sl4.size()); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (k >= sl4.size() || sl4[k] !== 4'(k)) begin
                errors++;
                $display("FAIL multi_slice%0d: got %h expected %h", k, (k < sl4.size()) ? sl4[k] : 4'bx, 4'(k));
            end
        end
        checks++;
        if (last4 - first4 + 1 != 16) begin errors++; $display("FAIL multi_gapless: span %0d expected 16", last4 - first4 + 1); end
        checks++;
        if (addr_pair4() !== 32'h0040_0041) begin errors++; $display("FAIL multi_addrs: got %h expected 00400041", addr_pair4()); end
    endtask

    task automatic test_latency();
        bit ok;
        latency = 10;
        clear_log();
        pulse_start4(16'h0040);
        wait_done4(600, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lat_timeout: done never rose"); end
        checks++;
        if (sl4.size() != 16) begin errors++; $display("FAIL lat_count: got %0d expected 16", sl4.size()); end
        checks++;
        if (stream4() !== 64'hFEDC_BA98_7654_3210) begin errors++; $display("FAIL lat_stream: got %h expected fedcba9876543210", stream4()); end
        // 8 slices, 5-cycle stall waiting for word 1, 8 slices
        checks++;
        if (last4 - first4 + 1 != 21) begin errors++; $display("FAIL lat_span: got %0d expected 21", last4 - first4 + 1); end
        checks++;
        if (addr_pair4() !== 32'h0040_0041) begin errors++; $display("FAIL lat_addrs: got %h expected 00400041", addr_pair4()); end
        latency = 1;
    endtask

    task automatic test_enable_toggle();
        bit ok;
        latency = 1;
        clear_log();
        enable1 = 1'b1;
        toggle1 = 1'b1;
        pulse_start1(16'h0010);
        repeat (20) @(negedge clock);
        pulse_start1(16'h0020);
        wait_done1(600, ok);
        toggle1 = 1'b0;
        @(negedge clock);
        enable1 = 1'b1;
        checks++;
        if (!ok) begin errors++; $display("FAIL toggle_timeout: done never rose"); end
        checks++;
        if (viol1 != 0) begin errors++; $display("FAIL toggle_gating: %0d shifts with enable low, expected 0", viol1); end
        checks++;
        if (stream1() !== 40'h3C_0000_00A5 || bits1.size() != 40) begin
            errors++;
            $display("FAIL toggle_stream: got %h (n=%0d) expected 3c000000a5 (n=40)", stream1(), bits1.size());
        end
        checks++;
        if (addr_pair1() !== 32'h0010_0011) begin errors++; $display("FAIL toggle_addrs: got %h expected 00100011", addr_pair1()); end
        checks++;
        if (last1 - first1 + 1 <= 40) begin errors++; $display("FAIL toggle_stalled: span %0d expected >40", last1 - first1 + 1); end
    endtask

    task automatic test_reset_midload();
        int n;
        latency = 1;
        clear_log();
        pulse_start1(16'h0010);
        n = 0;
        while (bits1.size() < 10 && n < 200) begin @(negedge clock); n++; end
        checks++;
        if (bits1.size() < 10) begin errors++; $display("FAIL abort_reach: got %0d bits expected >=10", bits1.size()); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({rd_req1, rd_addr1, bs1, shift_en1, busy1, done1} !== '0) begin
            errors++;
            $display("FAIL abort_async: got %h expected 0", {rd_req1, rd_addr1, bs1, shift_en1, busy1, done1});
        end
        @(negedge clock);
        reset_n = 1'b1;
        clear_log();
        inject1 = 1'b1;
        repeat (6) @(negedge clock);
        checks++;
        if ({busy1, done1} !== 2'b00 || addrs1.size() != 0 || bits1.size() != 0) begin
            errors++;
            $display("FAIL spurious_valid: busy,done %b reqs %0d bits %0d expected 00 0 0",
                     {busy1, done1}, addrs1.size(), bits1.size());
        end
    endtask

    task automatic test_restart();
        bit ok;
        latency = 1;
        run1(16'h0010, ok);
        checks++;
        if (!ok || stream1() !== 40'h3C_0000_00A5) begin
            errors++;
            $display("FAIL after_reset_stream: got %h (done=%0d) expected 3c000000a5", stream1(), ok);
        end
        clear_log();
        pulse_start1(16'h0020);
        checks++;
        if ({busy1, done1} !== 2'b10) begin errors++; $display("FAIL restart_flags: busy,done %b expected 10", {busy1, done1}); end
        wait_done1(400, ok);
        checks++;
        if (!ok || stream1() !== 40'h0F_8000_0001 || bits1.size() != 40) begin
            errors++;
            $display("FAIL restart_stream: got %h (n=%0d) expected 0f80000001 (n=40)", stream1(), bits1.size());
        end
        checks++;
        if (addr_pair1() !== 32'h0020_0021) begin errors++; $display("FAIL restart_addrs: got %h expected 00200021", addr_pair1()); end
        run1(16'hFFFF, ok);
        checks++;
        if (!ok || stream1() !== 40'h81_1234_5678) begin errors++; $display("FAIL wrap_stream: got %h expected 8112345678", stream1()); end
        checks++;
        if (addr_pair1() !== 32'hFFFF_0000) begin errors++; $display("FAIL wrap_addrs: got %h expected ffff0000", addr_pair1()); end
    endtask

`ifdef CONFIG_CRC_EN
    function automatic logic [15:0] crc_model(input logic [39:0] img);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < 40; i++) begin
            fb = c[15] ^ img[0];
            c = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
            img = img >> 1;
        end
        return c;
    endfunction

    task automatic test_crc();
        bit ok;
        logic [15:0] good;
        good = crc_model(40'h3C_0000_00A5);
        exp_crc1 = good ^ 16'h0001;
        run1(16'h0010, ok);
        checks++;
        if (!ok || crc_ok1 !== 1'b0) begin errors++; $display("FAIL crc_bad: crc_ok %b expected 0", crc_ok1); end
        exp_crc1 = good;
        run1(16'h0010, ok);
        checks++;
        if (crc1 !== good) begin errors++; $display("FAIL crc_value: got %h expected %h", crc1, good); end
        checks++;
        if (!ok || crc_ok1 !== 1'b1) begin errors++; $display("FAIL crc_good: crc_ok %b expected 1", crc_ok1); end
        clear_log();
        pulse_start1(16'h0010);
        checks++;
        if (crc_ok1 !== 1'b0) begin errors++; $display("FAIL crc_clear: crc_ok %b expected 0", crc_ok1); end
        wait_done1(400, ok);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'h0000_00A5;
        mem[8'h11] = 32'h0000_003C;
        mem[8'h20] = 32'h8000_0001;
        mem[8'h21] = 32'hFFFF_FF0F;
        mem[8'h40] = 32'h7654_3210;
        mem[8'h41] = 32'hFEDC_BA98;
        mem[8'hFF] = 32'h1234_5678;
        mem[8'h00] = 32'hABCD_0081;

        test_reset();
        test_basic_stream();
        test_multichain();
        test_latency();
        test_enable_toggle();
        test_reset_midload();
        test_restart();
`ifdef CONFIG_CRC_EN
        test_crc();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
